// File: rtl/urv_mem_arbiter.sv
// Single-port memory arbiter for the uRV core: fetch and load/store share one bus.
// One transaction in flight at a time; stale fetch data can be discarded after a branch.
module urv_mem_arbiter #(
  parameter bit g_data_priority = 1'b0,
  parameter bit g_discard_stale = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,

  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_o,
  output logic        mem_req_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] f_addr_q, f_addr_d;
  logic        d_pend_q, d_pend_d;
  logic        d_store_q, d_store_d;
  logic [31:2] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_sel_q, d_sel_d;
  logic [31:0] im_data_q, im_data_d;
  logic        im_valid_q, im_valid_d;
  logic [31:0] dm_data_l_q, dm_data_l_d;
  logic        ld_done_q, ld_done_d;
  logic        st_done_q, st_done_d;

  logic busy, arb_en, fetch_ack, load_ack, store_ack, data_done;
  logic data_cand, grant_data, dm_accept;

  // Byte offset of the data address never reaches the word-aligned bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dm_addr_i[1:0];

  assign busy      = (state_q != ST_IDLE);
  assign arb_en    = !busy || mem_ack_i;
  assign fetch_ack = (state_q == ST_FETCH) && mem_ack_i;
  assign load_ack  = (state_q == ST_LOAD)  && mem_ack_i;
  assign store_ack = (state_q == ST_STORE) && mem_ack_i;
  assign data_done = load_ack || store_ack;

  // The data slot completing this cycle must not win the arbitration it ends in.
  assign data_cand  = d_pend_q && !data_done;
  assign grant_data = data_cand && (g_data_priority || (last_grant_q == GRANT_FETCH));
  assign dm_accept  = (dm_load_i || dm_store_i) && !d_pend_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    f_addr_d     = f_addr_q;
    d_pend_d     = d_pend_q;
    d_store_d    = d_store_q;
    d_addr_d     = d_addr_q;
    d_wdata_d    = d_wdata_q;
    d_sel_d      = d_sel_q;
    im_data_d    = im_data_q;
    im_valid_d   = 1'b0;
    dm_data_l_d  = dm_data_l_q;
    ld_done_d    = 1'b0;
    st_done_d    = 1'b0;

    if (fetch_ack) begin
      im_data_d  = mem_rdata_i;
      im_valid_d = !g_discard_stale || (f_addr_q == im_addr_i);
    end
    if (load_ack) begin
      dm_data_l_d = mem_rdata_i;
      ld_done_d   = 1'b1;
    end
    if (store_ack) begin
      st_done_d = 1'b1;
    end
    if (data_done) begin
      d_pend_d = 1'b0;
    end

    if (dm_accept) begin
      d_pend_d  = 1'b1;
      d_store_d = dm_store_i;
      d_addr_d  = dm_addr_i[31:2];
      d_wdata_d = dm_data_s_i;
      d_sel_d   = dm_data_select_i;
    end

    if (arb_en) begin
      if (grant_data) begin
        state_d      = d_store_q ? ST_STORE : ST_LOAD;
        last_grant_d = GRANT_DATA;
      end else begin
        state_d      = ST_FETCH;
        f_addr_d     = im_addr_i;
        last_grant_d = GRANT_FETCH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DATA;
      f_addr_q     <= '0;
      d_pend_q     <= 1'b0;
      d_store_q    <= 1'b0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_sel_q      <= '0;
      im_data_q    <= '0;
      im_valid_q   <= 1'b0;
      dm_data_l_q  <= '0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      f_addr_q     <= f_addr_d;
      d_pend_q     <= d_pend_d;
      d_store_q    <= d_store_d;
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      d_sel_q      <= d_sel_d;
      im_data_q    <= im_data_d;
      im_valid_q   <= im_valid_d;
      dm_data_l_q  <= dm_data_l_d;
      ld_done_q    <= ld_done_d;
      st_done_q    <= st_done_d;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    case (state_q)
      ST_FETCH: mem_addr_o = {f_addr_q[31:2], 2'b00};
      ST_LOAD:  mem_addr_o = {d_addr_q, 2'b00};
      ST_STORE: begin
        mem_addr_o  = {d_addr_q, 2'b00};
        mem_wdata_o = d_wdata_q;
        mem_we_o    = d_sel_q;
      end
      default: ;
    endcase
  end

  assign mem_req_o       = busy;
  assign dm_ready_o      = !d_pend_q;
  assign im_data_o       = im_data_q;
  assign im_valid_o      = im_valid_q;
  assign dm_data_l_o     = dm_data_l_q;
  assign dm_load_done_o  = ld_done_q;
  assign dm_store_done_o = st_done_q;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter: a round-robin instance with a wait-state memory
// and a data-priority instance with a zero-wait memory.
module tb_urv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] im_addr;

  logic [31:0] im_data_a, dm_addr_a, dm_wdata_a, data_l_a, mem_addr_a, mem_wdata_a, rdata_a;
  logic [3:0]  dm_sel_a, mem_we_a;
  logic        im_valid_a, dm_load_a, dm_store_a, ready_a, ld_done_a, st_done_a, req_a, ack_a;

  logic [31:0] im_data_b, dm_addr_b, dm_wdata_b, data_l_b, mem_addr_b, mem_wdata_b, rdata_b;
  logic [3:0]  dm_sel_b, mem_we_b;
  logic        im_valid_b, dm_load_b, dm_store_b, ready_b, ld_done_b, st_done_b, req_b, ack_b;

  int wait_cfg;
  int cnt_a;
  int errors;
  int checks;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory A: acks after wait_cfg wait cycles. Memory B: always zero-wait.
  always @(posedge clk) begin
    if (!req_a || ack_a) cnt_a <= 0;
    else cnt_a <= cnt_a + 1;
  end
  assign ack_a   = req_a && (cnt_a == wait_cfg);
  assign rdata_a = ram_word(mem_addr_a);
  assign ack_b   = req_b;
  assign rdata_b = ram_word(mem_addr_b);

  urv_mem_arbiter #(.g_data_priority(1'b0), .g_discard_stale(1'b1)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_a), .im_valid_o(im_valid_a),
    .dm_addr_i(dm_addr_a), .dm_data_s_i(dm_wdata_a), .dm_data_select_i(dm_sel_a),
    .dm_load_i(dm_load_a), .dm_store_i(dm_store_a), .dm_ready_o(ready_a),
    .dm_data_l_o(data_l_a), .dm_load_done_o(ld_done_a), .dm_store_done_o(st_done_a),
    .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a), .mem_we_o(mem_we_a),
    .mem_req_o(req_a), .mem_rdata_i(rdata_a), .mem_ack_i(ack_a)
  );

  urv_mem_arbiter #(.g_data_priority(1'b1), .g_discard_stale(1'b1)) u_prio (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_b), .im_valid_o(im_valid_b),
    .dm_addr_i(dm_addr_b), .dm_data_s_i(dm_wdata_b), .dm_data_select_i(dm_sel_b),
    .dm_load_i(dm_load_b), .dm_store_i(dm_store_b), .dm_ready_o(ready_b),
    .dm_data_l_o(data_l_b), .dm_load_done_o(ld_done_b), .dm_store_done_o(st_done_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_we_o(mem_we_b),
    .mem_req_o(req_b), .mem_rdata_i(rdata_b), .mem_ack_i(ack_b)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        req;
    logic [31:0] maddr;
    logic [3:0]  we;
    logic        valid;
    logic        ldone;
    logic        sdone;
    logic        ready;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    dm_load_a = 1'b0; dm_store_a = 1'b0; dm_addr_a = '0; dm_wdata_a = '0; dm_sel_a = '0;
    dm_load_b = 1'b0; dm_store_b = 1'b0; dm_addr_b = '0; dm_wdata_b = '0; dm_sel_b = '0;
  endtask

  // Leaves the caller at the falling edge of the first cycle after the first grant edge.
  task automatic do_reset(input int w);
    rst_n = 1'b0;
    clear_inputs();
    im_addr  = 32'h100;
    wait_cfg = w;
    repeat (2) @(negedge clk);
    chk("rst_req_a",   {31'd0, req_a},      32'd0);
    chk("rst_ready_a", {31'd0, ready_a},    32'd1);
    chk("rst_valid_a", {31'd0, im_valid_a}, 32'd0);
    chk("rst_done_a",  {30'd0, ld_done_a, st_done_a}, 32'd0);
    chk("rst_req_b",   {31'd0, req_b},      32'd0);
    chk("rst_ready_b", {31'd0, ready_b},    32'd1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] grants_a;
    logic [5:0] grants_b;
    int         na;
    int         nb;
    logic       prev_req_a, prev_ack_a, prev_req_b, prev_ack_b;
    int         first_valid;
    logic [31:0] first_data;
    logic       saw_valid, saw_done;

    errors = 0;
    checks = 0;
    cnt_a  = 0;
    clear_inputs();
    im_addr  = 32'h100;
    wait_cfg = 0;
    #2 rst_n = 1'b0;

    // Zero-wait fetch stream with a load and then a store dropped in, one row per cycle.
    tbl[0] = '{1'b1, 1'b0, 32'h2004, 32'h0,        4'h0, 1'b1, 32'h100,  4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h100,  4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h2004, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h3000, 32'hAABBCCDD, 4'h3, 1'b1, 32'h100,  4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h100,  4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h3000, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h100,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h100,  4'h0, 1'b1, 1'b0, 1'b0, 1'b1};

    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      $display("row %0d: req=%0b addr=%08h we=%0h valid=%0b ldone=%0b sdone=%0b ready=%0b",
               i, req_a, mem_addr_a, mem_we_a, im_valid_a, ld_done_a, st_done_a, ready_a);
      chk($sformatf("tbl%0d_req", i),   {31'd0, req_a},      {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i),  mem_addr_a,          tbl[i].maddr);
      chk($sformatf("tbl%0d_we", i),    {28'd0, mem_we_a},   {28'd0, tbl[i].we});
      chk($sformatf("tbl%0d_valid", i), {31'd0, im_valid_a}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_ldone", i), {31'd0, ld_done_a},  {31'd0, tbl[i].ldone});
      chk($sformatf("tbl%0d_sdone", i), {31'd0, st_done_a},  {31'd0, tbl[i].sdone});
      chk($sformatf("tbl%0d_ready", i), {31'd0, ready_a},    {31'd0, tbl[i].ready});
      if (tbl[i].valid) chk($sformatf("tbl%0d_imdata", i), im_data_a, 32'h0000_0013);
      if (tbl[i].ldone) chk($sformatf("tbl%0d_ldata", i), data_l_a, 32'hDEAD_2004);
      if (tbl[i].we != 4'h0) chk($sformatf("tbl%0d_wdata", i), mem_wdata_a, 32'hAABB_CCDD);
      dm_load_a  = tbl[i].ld;
      dm_store_a = tbl[i].st;
      dm_addr_a  = tbl[i].daddr;
      dm_wdata_a = tbl[i].wdata;
      dm_sel_a   = tbl[i].sel;
      @(negedge clk);
    end
    clear_inputs();

    // Branch while a 3-wait fetch is outstanding: the 0x100 word must be dropped.
    do_reset(3);
    first_valid = 0;
    first_data  = '0;
    saw_valid   = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (im_valid_a && cyc <= 8) saw_valid = 1'b1;
      if (im_valid_a && first_valid == 0) begin
        first_valid = cyc;
        first_data  = im_data_a;
      end
      if (cyc == 5) begin
        chk("stale_refetch_req",  {31'd0, req_a}, 32'd1);
        chk("stale_refetch_addr", mem_addr_a, 32'h200);
      end
      if (cyc == 2) im_addr = 32'h200;
      @(negedge clk);
    end
    $display("stale fetch: first valid in cycle %0d data=%08h", first_valid, first_data);
    chk("stale_no_early_valid", {31'd0, saw_valid}, 32'd0);
    chk("stale_valid_cycle", first_valid, 32'd9);
    chk("stale_valid_data", first_data, 32'hDEAD_0200);

    // Back-to-back loads: A (1 wait, round-robin) and B (zero wait, data priority).
    do_reset(1);
    grants_a = '0; grants_b = '0; na = 0; nb = 0;
    prev_req_a = 1'b0; prev_ack_a = 1'b0; prev_req_b = 1'b0; prev_ack_b = 1'b0;
    for (int cyc = 1; cyc <= 40 && (na < 6 || nb < 6); cyc++) begin
      if (req_a && (prev_ack_a || !prev_req_a) && na < 6) begin
        grants_a[na] = (mem_addr_a != 32'h100);
        na++;
      end
      if (req_b && (prev_ack_b || !prev_req_b) && nb < 6) begin
        grants_b[nb] = (mem_addr_b != 32'h100);
        nb++;
      end
      prev_req_a = req_a; prev_ack_a = ack_a;
      prev_req_b = req_b; prev_ack_b = ack_b;
      dm_load_a = ready_a; dm_addr_a = 32'h2008;
      dm_load_b = ready_b; dm_addr_b = 32'h2008;
      @(negedge clk);
    end
    clear_inputs();
    $display("grant order (bit0 first, 1=data): rr=%06b prio=%06b", grants_a, grants_b);
    chk("rr_grant_count", na, 32'd6);
    chk("rr_interleave", {26'd0, grants_a}, 32'b101010);
    chk("prio_grant_count", nb, 32'd6);
    chk("prio_grants", {26'd0, grants_b}, 32'b100100);

    // Load and store together count as a store; the bus address is word aligned.
    do_reset(0);
    dm_load_b = 1'b1; dm_store_b = 1'b1; dm_addr_b = 32'h4007;
    dm_wdata_b = 32'h1122_3344; dm_sel_b = 4'hF;
    @(negedge clk);
    clear_inputs();
    chk("both_ready_low", {31'd0, ready_b}, 32'd0);
    @(negedge clk);
    $display("ld+st: req=%0b addr=%08h we=%0h wdata=%08h", req_b, mem_addr_b, mem_we_b, mem_wdata_b);
    chk("both_addr_aligned", mem_addr_b, 32'h4004);
    chk("both_we", {28'd0, mem_we_b}, 32'hF);
    chk("both_wdata", mem_wdata_b, 32'h1122_3344);
    @(negedge clk);
    chk("both_store_done", {31'd0, st_done_b}, 32'd1);
    chk("both_no_load_done", {31'd0, ld_done_b}, 32'd0);
    chk("both_ready_back", {31'd0, ready_b}, 32'd1);

    // Reset during a 3-wait store: request drops at once and no done pulse follows.
    do_reset(3);
    dm_store_a = 1'b1; dm_addr_a = 32'h3000; dm_wdata_a = 32'hAABB_CCDD; dm_sel_a = 4'h3;
    @(negedge clk);
    clear_inputs();
    repeat (4) @(negedge clk);
    $display("mid-reset: req=%0b addr=%08h we=%0h before reset", req_a, mem_addr_a, mem_we_a);
    chk("mrst_store_active", {28'd0, mem_we_a}, 32'h3);
    chk("mrst_store_addr", mem_addr_a, 32'h3000);
    rst_n = 1'b0;
    #1;
    chk("mrst_req_async", {31'd0, req_a}, 32'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (st_done_a) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    #1;
    chk("mrst_idle_after", {31'd0, req_a}, 32'd0);
    chk("mrst_ready_after", {31'd0, ready_a}, 32'd1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (st_done_a) saw_done = 1'b1;
      if (cyc == 0) chk("mrst_first_fetch", mem_addr_a, 32'h100);
    end
    chk("mrst_no_store_done", {31'd0, saw_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
